// File: rtl/pred_pkg.sv
// Shared constants, helpers and checkpoint-op encoding for the predicate register file.
package pred_pkg;

  localparam int unsigned DEF_REG_BITS   = 3;
  localparam int unsigned DEF_CKPT_DEPTH = 4;
  localparam int unsigned PRED_TRUE      = 0;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_RELEASE,
    OP_RESTORE
  } ckpt_op_e;

  function automatic int unsigned num_reg(input int unsigned reg_bits);
    return 32'(1) << reg_bits;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Only one checkpoint op runs per cycle: restore > release > push.
  function automatic ckpt_op_e ckpt_op_sel(input logic push, input logic restore,
                                           input logic rel);
    if (restore)   return OP_RESTORE;
    else if (rel)  return OP_RELEASE;
    else if (push) return OP_PUSH;
    else           return OP_NONE;
  endfunction

endpackage

// File: rtl/pred_reg_file_ckpt_if.sv
// Bus bundle between decode/writeback/branch unit and the predicate register file.
interface pred_reg_file_ckpt_if
  import pred_pkg::*;
#(
  parameter int unsigned REG_BITS   = DEF_REG_BITS,
  parameter int unsigned NUM_RD     = 3,
  parameter int unsigned NUM_WR     = 2,
  parameter int unsigned CKPT_DEPTH = DEF_CKPT_DEPTH
);
  localparam int unsigned NUM_REG = num_reg(REG_BITS);
  localparam int unsigned CNT_W   = cnt_w(CKPT_DEPTH);

  logic [NUM_RD*REG_BITS-1:0] rd_addr;
  logic [NUM_RD-1:0]          rd_data;
  logic [NUM_WR-1:0]          wr_en;
  logic [NUM_WR*REG_BITS-1:0] wr_addr;
  logic [NUM_WR-1:0]          wr_data;
  logic                       ckpt_push;
  logic                       ckpt_restore;
  logic                       ckpt_release;
  logic [NUM_REG-1:0]         pred_vec;
  logic [CNT_W-1:0]           ckpt_count;
  logic                       ckpt_full;
  logic                       ckpt_empty;
  logic                       ckpt_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, ckpt_push, ckpt_restore, ckpt_release,
    input  rd_data, pred_vec, ckpt_count, ckpt_full, ckpt_empty, ckpt_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, ckpt_push, ckpt_restore, ckpt_release,
    output rd_data, pred_vec, ckpt_count, ckpt_full, ckpt_empty, ckpt_err
  );

endinterface

// File: rtl/pred_ckpt_stack.sv
// LIFO of predicate snapshots with occupancy count and a one-cycle error pulse.
module pred_ckpt_stack
  import pred_pkg::*;
#(
  parameter int unsigned NUM_REG    = 8,
  parameter int unsigned CKPT_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic                          restore_i,
  input  logic                          release_i,
  input  logic [NUM_REG-1:0]            snap_i,
  output logic [NUM_REG-1:0]            top_o,
  output logic                          restore_go_o,
  output logic [cnt_w(CKPT_DEPTH)-1:0]  count_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          err_o
);
  localparam int unsigned CNT_W = cnt_w(CKPT_DEPTH);
  localparam int unsigned IDX_W = $clog2(CKPT_DEPTH);

  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx, top_idx;
  logic [NUM_REG-1:0] mem_q [CKPT_DEPTH];
  ckpt_op_e           op;

  assign op           = ckpt_op_sel(push_i, restore_i, release_i);
  assign full_o       = (count_q == CNT_W'(CKPT_DEPTH));
  assign empty_o      = (count_q == '0);
  assign wr_idx       = IDX_W'(count_q);
  assign top_idx      = IDX_W'(count_q - CNT_W'(1));
  assign top_o        = mem_q[top_idx];
  assign restore_go_o = restore_i & ~empty_o;
  assign count_o      = count_q;
  assign err_o        = err_q;

  // Dropped lower-priority ops and illegal pushes/pops both raise the error pulse.
  always_comb begin
    count_d = count_q;
    err_d   = (push_i & restore_i) | (push_i & release_i) | (restore_i & release_i);
    wr_en   = 1'b0;
    case (op)
      OP_PUSH: begin
        if (full_o) begin
          err_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
          wr_en   = 1'b1;
        end
      end
      OP_RELEASE, OP_RESTORE: begin
        if (empty_o) err_d = 1'b1;
        else         count_d = count_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem_q[wr_idx] <= snap_i;
  end

endmodule

// File: rtl/pred_reg_file_ckpt.sv
// Predicate register file: multi-port read with write bypass, prioritised writes, checkpoint rollback.
module pred_reg_file_ckpt
  import pred_pkg::*;
#(
  parameter int unsigned REG_BITS   = DEF_REG_BITS,
  parameter int unsigned NUM_RD     = 3,
  parameter int unsigned NUM_WR     = 2,
  parameter int unsigned CKPT_DEPTH = DEF_CKPT_DEPTH
) (
  input logic                clk,
  input logic                reset,
  pred_reg_file_ckpt_if.slave bus
);
  localparam int unsigned NUM_REG = num_reg(REG_BITS);

  logic [NUM_REG-1:0]  live_q, live_d;
  logic [NUM_REG-1:0]  snap_top;
  logic                restore_go;
  logic [NUM_RD-1:0]   rd_c;
  logic [REG_BITS-1:0] ra [NUM_RD];
  logic [REG_BITS-1:0] wa [NUM_WR];

  for (genvar k = 0; k < NUM_RD; k++) begin : g_ra
    assign ra[k] = bus.rd_addr[k*REG_BITS +: REG_BITS];
  end

  for (genvar w = 0; w < NUM_WR; w++) begin : g_wa
    assign wa[w] = bus.wr_addr[w*REG_BITS +: REG_BITS];
  end

  pred_ckpt_stack #(
    .NUM_REG    (NUM_REG),
    .CKPT_DEPTH (CKPT_DEPTH)
  ) u_stack (
    .clk          (clk),
    .reset        (reset),
    .push_i       (bus.ckpt_push),
    .restore_i    (bus.ckpt_restore),
    .release_i    (bus.ckpt_release),
    .snap_i       (live_q),
    .top_o        (snap_top),
    .restore_go_o (restore_go),
    .count_o      (bus.ckpt_count),
    .full_o       (bus.ckpt_full),
    .empty_o      (bus.ckpt_empty),
    .err_o        (bus.ckpt_err)
  );

  // Later ports overwrite earlier ones so the highest-index writer wins; a restore discards all writes.
  always_comb begin
    live_d = live_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (bus.wr_en[w] && (wa[w] != '0)) live_d[wa[w]] = bus.wr_data[w];
    end
    if (restore_go) live_d = snap_top;
    live_d[PRED_TRUE] = 1'b1;
  end

  // Write-through bypass, disabled during a restore so reads see pre-rollback state.
  always_comb begin
    rd_c = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_c[k] = live_q[ra[k]];
      if (!bus.ckpt_restore && (ra[k] != '0)) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (bus.wr_en[w] && (wa[w] == ra[k])) rd_c[k] = bus.wr_data[w];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) live_q <= NUM_REG'(1);
    else       live_q <= live_d;
  end

  assign bus.rd_data  = rd_c;
  assign bus.pred_vec = live_q;

endmodule

// File: tb/tb_pred_reg_file_ckpt.sv
// Scoreboard bench: driver pushes model predictions, a negedge monitor pops and compares.
module tb_pred_reg_file_ckpt;
  localparam int unsigned RB   = 3;
  localparam int unsigned NR   = 3;
  localparam int unsigned NW   = 2;
  localparam int unsigned CD   = 4;
  localparam int unsigned NREG = 8;
  localparam int unsigned CW   = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pred_reg_file_ckpt_if #(.REG_BITS(RB), .NUM_RD(NR), .NUM_WR(NW), .CKPT_DEPTH(CD)) bus ();

  pred_reg_file_ckpt #(.REG_BITS(RB), .NUM_RD(NR), .NUM_WR(NW), .CKPT_DEPTH(CD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [NR-1:0]   rd;
    logic [NREG-1:0] pv;
    logic [CW-1:0]   cnt;
    logic            full;
    logic            empty;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference state: live predicates as a bit vector, checkpoints as a queue (back = top).
  logic [NREG-1:0] m_live;
  logic [NREG-1:0] m_stk[$];
  logic            m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rd_data",    32'(bus.rd_data),    32'(e.rd));
      chk("pred_vec",   32'(bus.pred_vec),   32'(e.pv));
      chk("ckpt_count", 32'(bus.ckpt_count), 32'(e.cnt));
      chk("ckpt_full",  32'(bus.ckpt_full),  32'(e.full));
      chk("ckpt_empty", 32'(bus.ckpt_empty), 32'(e.empty));
      chk("ckpt_err",   32'(bus.ckpt_err),   32'(e.err));
    end
  end

  task automatic cycle(input logic rst, input logic psh, input logic rsr, input logic rel,
                       input logic [NW-1:0] we, input logic [NW*RB-1:0] wa,
                       input logic [NW-1:0] wd, input logic [NR*RB-1:0] ra);
    exp_t e;
    int   a;
    int   nops;
    bit   do_wr;
    reset            = rst;
    bus.ckpt_push    = psh;
    bus.ckpt_restore = rsr;
    bus.ckpt_release = rel;
    bus.wr_en        = we;
    bus.wr_addr      = wa;
    bus.wr_data      = wd;
    bus.rd_addr      = ra;

    for (int k = 0; k < NR; k++) begin
      a = int'(ra[k*RB +: RB]);
      e.rd[k] = m_live[a];
      if (a != 0 && !rsr)
        for (int w = 0; w < NW; w++)
          if (we[w] && int'(wa[w*RB +: RB]) == a) e.rd[k] = wd[w];
    end
    e.pv    = m_live;
    e.cnt   = CW'(m_stk.size());
    e.full  = (m_stk.size() == CD);
    e.empty = (m_stk.size() == 0);
    e.err   = m_err;
    exp_q.push_back(e);

    if (rst) begin
      m_live = NREG'(1);
      m_stk.delete();
      m_err = 1'b0;
    end else begin
      nops  = int'(psh) + int'(rsr) + int'(rel);
      m_err = (nops > 1);
      do_wr = 1'b1;
      if (rsr) begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else begin
          m_live = m_stk.pop_back();
          do_wr  = 1'b0;
        end
      end else if (rel) begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else void'(m_stk.pop_back());
      end else if (psh) begin
        if (m_stk.size() == CD) m_err = 1'b1;
        else m_stk.push_back(m_live);
      end
      if (do_wr)
        for (int w = 0; w < NW; w++)
          if (we[w] && wa[w*RB +: RB] != '0) m_live[wa[w*RB +: RB]] = wd[w];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [NR*RB-1:0] ra);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, ra);
  endtask

  initial begin
    reset            = 1'b1;
    bus.ckpt_push    = 1'b0;
    bus.ckpt_restore = 1'b0;
    bus.ckpt_release = 1'b0;
    bus.wr_en        = '0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.rd_addr      = '0;
    m_live           = NREG'(1);
    m_err            = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then p3 written via port0 and read on every port
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 6'o00, 2'b00, 9'o333);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 6'o03, 2'b01, 9'o333);
    idle(9'o333);
    // Conflicting writes to p5 (port1 wins, bypassed), then write to p0
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 6'o55, 2'b10, 9'o555);
    idle(9'o555);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 6'o00, 2'b00, 9'o050);
    idle(9'o050);
    // Checkpoint p2=1, clobber p2/p4, then roll back
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 6'o02, 2'b01, 9'o242);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 6'o00, 2'b00, 9'o242);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 6'o42, 2'b10, 9'o242);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 6'o24, 2'b01, 9'o242);
    idle(9'o242);
    // Fill the stack, overflow once, then drain by release
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 6'o00, 2'b00, 9'o123);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 6'o00, 2'b00, 9'o123);
    idle(9'o123);
    idle(9'o456);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 6'o00, 2'b00, 9'o456);
    idle(9'o456);
    // Restore on empty with a write, then push+restore at count 1
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 6'o06, 2'b01, 9'o666);
    idle(9'o666);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 6'o00, 2'b00, 9'o666);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 6'o70, 2'b10, 9'o777);
    idle(9'o777);
    // Reset overrides a pending restore
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 6'o00, 2'b00, 9'o123);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 6'o00, 2'b00, 9'o123);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 6'o71, 2'b11, 9'o123);
    idle(9'o176);

    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 63) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0,
            2'($urandom), 6'($urandom), 2'($urandom), 9'($urandom));
    end
    idle(9'o000);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
